multicycle_control_unit: RTL



---
 rtl/mcu_pkg.sv | 25 ++
 rtl/alu_op_decode.sv | 33 +++
 rtl/multicycle_control_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
// mcu_pkg: state, opcode and ALU-code encodings shared by the
// multicycle control unit and its ALU operand decoder.
package mcu_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_LW   = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_BEQ  = 3'd5;
    localparam logic [2:0] OP_LAST = 3'd5;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: latched opcode -> {ALUSrc, ALUControl}, shared by
// the EXEC, MEM and WB phases.
module alu_op_decode
    import mcu_pkg::*;
#(
    parameter int OPCODE_W  = 3,
    parameter int ALUCTRL_W = 2
) (
    input  logic [OPCODE_W-1:0]  i_op,
    output logic                 o_alu_src,
    output logic [ALUCTRL_W-1:0] o_alu_ctrl
);

    logic w_is_imm;
    logic w_is_sub;

    assign w_is_imm = (i_op == OPCODE_W'(OP_ADDI)) ||
                      (i_op == OPCODE_W'(OP_LW))   ||
                      (i_op == OPCODE_W'(OP_SW));
    assign w_is_sub = (i_op == OPCODE_W'(OP_SUB)) ||
                      (i_op == OPCODE_W'(OP_BEQ));

    always_comb begin
        o_alu_src  = 1'b0;
        o_alu_ctrl = ALUCTRL_W'(ALU_ADD);
        unique case (1'b1)
            w_is_imm: o_alu_src  = 1'b1;
            w_is_sub: o_alu_ctrl = ALUCTRL_W'(ALU_SUB);
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer with retire counter.
// Define ILLEGAL_OP_TRAP_EN to trap illegal opcodes (adds illegal_op output).
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int OPCODE_W  = 3,
    parameter int ALUCTRL_W = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPCODE_W-1:0]  Opcode,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 ALUSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 RegWrite,
    output logic                 Branch,
    output logic                 instr_done,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic                 illegal_op,
`endif
    output logic [2:0]           state_o,
    output logic [CNT_W-1:0]     instr_cnt
);

    state_t                r_state;
    logic [OPCODE_W-1:0]   r_op;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_alu_src;
    logic [ALUCTRL_W-1:0]  w_alu_ctrl;
    logic                  w_is_lw;
    logic                  w_is_sw;
    logic                  w_is_beq;
    logic                  w_illegal;

    alu_op_decode #(
        .OPCODE_W  (OPCODE_W),
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_op_decode (
        .i_op       (r_op),
        .o_alu_src  (w_alu_src),
        .o_alu_ctrl (w_alu_ctrl)
    );

    assign w_is_lw   = (r_op == OPCODE_W'(OP_LW));
    assign w_is_sw   = (r_op == OPCODE_W'(OP_SW));
    assign w_is_beq  = (r_op == OPCODE_W'(OP_BEQ));
    assign w_illegal = (Opcode > OPCODE_W'(OP_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_op    <= '0;
            r_cnt   <= '0;
        end else begin
            if (instr_done)
                r_cnt <= r_cnt + CNT_W'(1);
            unique case (r_state)
                S_FETCH:
                    if (mem_ready)
                        r_state <= S_DECODE;
                S_DECODE: begin
                    r_op <= Opcode;
`ifdef ILLEGAL_OP_TRAP_EN
                    r_state <= w_illegal ? S_TRAP : S_EXEC;
`else
                    r_state <= w_illegal ? S_FETCH : S_EXEC;
`endif
                end
                S_EXEC:
                    if (w_is_beq)
                        r_state <= S_FETCH;
                    else if (w_is_lw || w_is_sw)
                        r_state <= S_MEM;
                    else
                        r_state <= S_WB;
                S_MEM:
                    if (mem_ready)
                        r_state <= w_is_lw ? S_WB : S_FETCH;
                S_WB:
                    r_state <= S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
                S_TRAP:
                    r_state <= S_TRAP;
`endif
                default:
                    r_state <= S_FETCH;
            endcase
        end
    end

    // Gated by rst_n so an asserted reset silences every enable at once.
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        ALUSrc     = 1'b0;
        ALUControl = '0;
        RegWrite   = 1'b0;
        Branch     = 1'b0;
        instr_done = 1'b0;
        if (rst_n) begin
            unique case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_EXEC: begin
                    ALUSrc     = w_alu_src;
                    ALUControl = w_alu_ctrl;
                    Branch     = w_is_beq;
                    instr_done = w_is_beq;
                end
                S_MEM: begin
                    ALUSrc     = w_alu_src;
                    ALUControl = w_alu_ctrl;
                    MemRead    = w_is_lw;
                    MemWrite   = w_is_sw;
                    instr_done = w_is_sw && mem_ready;
                end
                S_WB: begin
                    ALUSrc     = w_alu_src;
                    ALUControl = w_alu_ctrl;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal_op = rst_n && (r_state == S_TRAP);
`endif

    assign state_o   = r_state;
    assign instr_cnt = r_cnt;

endmodule
